spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- RTL SPI slave; the counterpart of the master-side bench driver. It receives MOSI bytes and returns MISO bytes.
- Oversamples SPI_Clk, SPI_CS_n and SPI_MOSI on the system clock i_Clk through 2-FF synchronizers.
- Exposes a byte-level RX valid pulse and a TX ready/valid load port to on-chip logic.
- The SPI slave DUT targeted by the master-side UVM agent (driver on MOSI, monitor on MOSI/MISO).

Parameters:
- SPI_MODE, 0, {CPOL,CPHA}: 0..3. Selects SPI_Clk idle level and sample/shift edges.
- DATA_WIDTH, 8, bits per SPI word, shifted MSB first.
- IDLE_FILL, 8'hFF, word sent on MISO when no TX word is buffered (width DATA_WIDTH).

Ports:
- i_Clk  in  1  system clock, must be >= 4x SPI_Clk frequency.
- i_Rst  in  1  synchronous, active-high reset.
- i_TX_DV  in  1  TX word valid; accepted only when o_TX_Ready=1.
- i_TX_Byte  in  DATA_WIDTH  TX word to send on MISO.
- o_TX_Ready  out  1  TX holding buffer empty.
- o_TX_Underrun  out  1  1-cycle pulse: IDLE_FILL was loaded because the buffer was empty.
- o_RX_DV  out  1  1-cycle pulse: o_RX_Byte valid.
- o_RX_Byte  out  DATA_WIDTH  last complete received word.
- SPI_Clk  in  1  serial clock from master (asynchronous to i_Clk).
- SPI_CS_n  in  1  chip select, active low.
- SPI_MOSI  in  1  serial data from master.
- SPI_MISO  out  1  serial data to master.
- o_MISO_En  out  1  MISO output enable (1 while CS active); drives the pad tri-state.

Behaviour:
Reset (i_Rst=1 at a rising edge of i_Clk):
- All outputs go to 0 except o_TX_Ready=1 and SPI_MISO=1.
- Synchronizer flops are set to idle values: CS=1, SCK=CPOL.
- Reset overrides any in-flight transfer. The partial word is discarded and no RX_DV is issued.

Synchronization:
- Each SPI input passes through 2 flops.
- Edge detect compares synced SCK against its 1-cycle-delayed copy.
- Total latency from a pin edge to the internal event is 3 i_Clk cycles.
- Leading edge = edge away from CPOL; trailing edge = edge back to CPOL.
- CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.

FSM states:
- IDLE -> LOAD on synced CS falling.
- LOAD (1 cycle) -> SHIFT.
- SHIFT -> IDLE on synced CS rising, from any state.

State actions:
- LOAD: TX shift register gets the holding buffer, or IDLE_FILL if the buffer is empty (and o_TX_Underrun pulses). The buffer is emptied and the bit counter is cleared.
- LOAD, CPHA=0: SPI_MISO is driven with the MSB at the end of LOAD.
- LOAD, CPHA=1: the MSB is driven on the first leading edge.
- SHIFT, each sample edge: shift in synced MOSI and increment the bit counter.
- At count DATA_WIDTH:
  - The next cycle, o_RX_Byte is updated and o_RX_DV pulses.
  - The counter wraps to 0.
  - The TX shift register reloads from the buffer (or IDLE_FILL with an underrun pulse), same rule as LOAD.
- SHIFT, each shift edge: SPI_MISO takes the next bit. The first CPHA=0 trailing edge after a reload must not skip the reloaded MSB.

Chip select and MISO:
- CS rising mid-word: the partial RX word is dropped (no RX_DV) and the counter is cleared.
- A buffered TX word not yet loaded is retained for the next frame.
- o_MISO_En = !synced CS, registered. SPI_MISO holds 1 while o_MISO_En=0.

TX handshake:
- A write occurs when i_TX_DV && o_TX_Ready. o_TX_Ready falls the next cycle.
- o_TX_Ready rises the cycle after the buffer transfers to the shift register.
- If a write and a buffer load occur in the same cycle: the load takes the old state (empty means IDLE_FILL plus underrun), and the write then fills the buffer.
- i_TX_DV while o_TX_Ready=0 is ignored.

Test Plan:
1. Mode 0: preload 8'h3C, master sends 8'hA5 in one frame at i_Clk/8 -> o_RX_DV pulses once with o_RX_Byte=8'hA5, bench samples MISO=8'h3C, underrun never pulses.
2. Mode 0, back-to-back: preload 8'h11, write 8'h22 after o_TX_Ready re-rises, master sends 8'hC3, 8'h5A in one CS frame -> RX_DV twice (C3, 5A), MISO returns 11 then 22.
3. Underrun: no preload, master sends 8'h0F -> o_TX_Underrun pulses in LOAD, MISO=8'hFF, RX=8'h0F.
4. Abort: CS rises after 5 SCK cycles -> no o_RX_DV. The next full frame 8'h81 yields RX=8'h81 (counter cleared). o_MISO_En=0 between frames.
5. Mode 3 (CPOL=1, CPHA=1): preload 8'hE7, master sends 8'h96 -> RX=8'h96, MISO=8'hE7, SCK idles high throughout.
6. Reset at bit 4 of a frame -> all outputs return to reset values the next cycle, o_TX_Ready=1, no RX_DV. A following clean frame 8'h3C is received correctly.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI slave core: SCK/CS/MOSI oversampled on i_Clk through 2-FF synchronizers,
// MSB-first shift registers, byte RX valid pulse and a one-word TX holding buffer.
module spi_slave_core #(
    parameter int unsigned               SPI_MODE   = 0,
    parameter int unsigned               DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]     IDLE_FILL  = 8'hFF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_TX_DV,
    input  logic [DATA_WIDTH-1:0] i_TX_Byte,
    output logic                  o_TX_Ready,
    output logic                  o_TX_Underrun,
    output logic                  o_RX_DV,
    output logic [DATA_WIDTH-1:0] o_RX_Byte,
    input  logic                  SPI_Clk,
    input  logic                  SPI_CS_n,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    output logic                  o_MISO_En
);
    localparam logic CPOL = (SPI_MODE & 2) != 0;
    localparam logic CPHA = (SPI_MODE & 1) != 0;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    sck_meta_q, sck_sync_q, sck_prev_q;
    logic                    cs_meta_q, cs_sync_q, cs_prev_q;
    logic                    mosi_meta_q, mosi_sync_q;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_byte_q, rx_byte_d;
    logic                    rx_dv_q, rx_dv_d;
    logic                    underrun_q, underrun_d;
    logic                    miso_q, miso_d;
    logic                    miso_en_q, miso_en_d;

    logic                    leading_edge, trailing_edge;
    logic                    sample_edge, shift_edge, cs_fall, do_load;
    logic [DATA_WIDTH-1:0]   load_word, rx_next;

    assign leading_edge  = (sck_sync_q != CPOL) && (sck_prev_q == CPOL);
    assign trailing_edge = (sck_sync_q == CPOL) && (sck_prev_q != CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge  : trailing_edge;
    assign cs_fall       = !cs_sync_q && cs_prev_q;
    assign load_word     = tx_full_q ? tx_buf_q : IDLE_FILL;
    assign rx_next       = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q};

    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        underrun_d = 1'b0;
        miso_d     = miso_q;
        miso_en_d  = !cs_sync_q;
        do_load    = 1'b0;

        if (state_q != S_IDLE && cs_sync_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cs_fall) state_d = S_LOAD;
                end
                S_LOAD: begin
                    do_load = 1'b1;
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_LAST) begin
                            rx_byte_d = rx_next;
                            rx_dv_d   = 1'b1;
                        end
                    end
                    // With CPHA=0 the MSB is already on MISO after a (re)load, so a
                    // shift edge before the word's first sample must not advance it.
                    if (shift_edge && (CPHA || bit_cnt_q != '0)) begin
                        miso_d     = tx_shift_q[DATA_WIDTH-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                    if (bit_cnt_q == CNT_FULL) do_load = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_load) begin
            bit_cnt_d  = '0;
            underrun_d = !tx_full_q;
            tx_full_d  = 1'b0;
            if (CPHA) begin
                tx_shift_d = load_word;
            end else begin
                tx_shift_d = load_word << 1;
                miso_d     = load_word[DATA_WIDTH-1];
            end
        end

        // A write in the same cycle as a load lands after the load has taken the old state.
        if (i_TX_DV && !tx_full_q) begin
            tx_buf_d  = i_TX_Byte;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= S_IDLE;
            sck_meta_q  <= CPOL;
            sck_sync_q  <= CPOL;
            sck_prev_q  <= CPOL;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b1;
            miso_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_meta_q  <= SPI_Clk;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= SPI_CS_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= SPI_MOSI;
            mosi_sync_q <= mosi_meta_q;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
        end
    end

    assign o_TX_Ready    = !tx_full_q;
    assign o_TX_Underrun = underrun_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Byte     = rx_byte_q;
    assign SPI_MISO      = miso_q;
    assign o_MISO_En     = miso_en_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: one mode-0 and one mode-3 instance driven by a
// bit-banged master at i_Clk/8, table-driven single frames plus corner sequences.
module tb_spi_slave_core;

    logic       clk;
    logic       rst;
    logic       tx_dv    [2];
    logic [7:0] tx_byte  [2];
    logic       tx_ready [2];
    logic       und      [2];
    logic       rx_dv    [2];
    logic [7:0] rx_byte  [2];
    logic       sck      [2];
    logic       cs_n     [2];
    logic       mosi     [2];
    logic       miso     [2];
    logic       miso_en  [2];

    spi_slave_core #(.SPI_MODE(0), .DATA_WIDTH(8), .IDLE_FILL(8'hFF)) u_dut0 (
        .i_Clk(clk), .i_Rst(rst),
        .i_TX_DV(tx_dv[0]), .i_TX_Byte(tx_byte[0]),
        .o_TX_Ready(tx_ready[0]), .o_TX_Underrun(und[0]),
        .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
        .SPI_Clk(sck[0]), .SPI_CS_n(cs_n[0]), .SPI_MOSI(mosi[0]),
        .SPI_MISO(miso[0]), .o_MISO_En(miso_en[0])
    );

    spi_slave_core #(.SPI_MODE(3), .DATA_WIDTH(8), .IDLE_FILL(8'hFF)) u_dut3 (
        .i_Clk(clk), .i_Rst(rst),
        .i_TX_DV(tx_dv[1]), .i_TX_Byte(tx_byte[1]),
        .o_TX_Ready(tx_ready[1]), .o_TX_Underrun(und[1]),
        .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
        .SPI_Clk(sck[1]), .SPI_CS_n(cs_n[1]), .SPI_MOSI(mosi[1]),
        .SPI_MISO(miso[1]), .o_MISO_En(miso_en[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors: count RX_DV / underrun pulses, keep the last two RX words.
    int         rx_cnt    [2];
    int         und_cnt   [2];
    int         und_at_rx [2];
    logic [7:0] rx_last   [2];
    logic [7:0] rx_prev   [2];

    always @(negedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (rx_dv[i] === 1'b1) begin
                rx_cnt[i]    = rx_cnt[i] + 1;
                rx_prev[i]   = rx_last[i];
                rx_last[i]   = rx_byte[i];
                und_at_rx[i] = und_cnt[i];
            end
            if (und[i] === 1'b1) und_cnt[i] = und_cnt[i] + 1;
        end
    end

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input int s, input logic [7:0] b);
        tx_byte[s] = b;
        tx_dv[s]   = 1'b1;
        @(negedge clk);
        tx_dv[s]   = 1'b0;
    endtask

    // One word, CS assumed low. s=0: mode 0 master, s=1: mode 3 master.
    task automatic xfer(input int s, input logic [7:0] mo, output logic [7:0] mi);
        logic [7:0] r;
        int         b;
        r = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            b = 7 - int'(k);
            if (s == 0) begin
                mosi[s] = mo[b];
                wait_clk(4);
                sck[s]  = 1'b1;
                r[b]    = miso[s];
                wait_clk(4);
                sck[s]  = 1'b0;
            end else begin
                sck[s]  = 1'b0;
                mosi[s] = mo[b];
                wait_clk(4);
                sck[s]  = 1'b1;
                r[b]    = miso[s];
                wait_clk(4);
            end
        end
        mi = r;
    endtask

    task automatic frame(input int s, input logic [7:0] mo, output logic [7:0] mi);
        cs_n[s] = 1'b0;
        wait_clk(8);
        xfer(s, mo, mi);
        wait_clk(4);
        cs_n[s] = 1'b1;
        wait_clk(8);
    endtask

    typedef struct {
        int         sel;
        bit         pre;
        logic [7:0] pre_b;
        bit         junk;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
        int         exp_und;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] mi, mi2;
    int         r0, u0, s;
    logic       ok;

    initial begin
        vecs[0] = '{0, 1'b1, 8'h3C, 1'b1, 8'hA5, 8'hA5, 8'h3C, 0};
        vecs[1] = '{0, 1'b0, 8'h00, 1'b0, 8'h0F, 8'h0F, 8'hFF, 1};
        vecs[2] = '{1, 1'b1, 8'hE7, 1'b0, 8'h96, 8'h96, 8'hE7, 0};
        vecs[3] = '{1, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h5A, 8'hFF, 1};
        vecs[4] = '{0, 1'b1, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'h00, 0};

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            tx_dv[i]   = 1'b0;
            tx_byte[i] = '0;
            cs_n[i]    = 1'b1;
            mosi[i]    = 1'b0;
            rx_last[i] = '0;
            rx_prev[i] = '0;
        end
        sck[0] = 1'b0;
        sck[1] = 1'b1;

        wait_clk(3);
        for (int unsigned i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i),   tx_ready[i], 1);
            chk($sformatf("rst_miso%0d", i),    miso[i],     1);
            chk($sformatf("rst_misoen%0d", i),  miso_en[i],  0);
            chk($sformatf("rst_rxbyte%0d", i),  rx_byte[i],  0);
            chk($sformatf("rst_rxdv%0d", i),    rx_dv[i],    0);
        end
        rst = 1'b0;
        wait_clk(4);

        for (int unsigned v = 0; v < 5; v++) begin
            s = vecs[v].sel;
            if (vecs[v].pre) begin
                tx_write(s, vecs[v].pre_b);
                chk($sformatf("v%0d_ready_low", v), tx_ready[s], 0);
                if (vecs[v].junk) tx_write(s, 8'h99);
            end
            r0 = rx_cnt[s];
            u0 = und_cnt[s];
            frame(s, vecs[v].mo, mi);
            chk($sformatf("v%0d_rx_pulses", v), rx_cnt[s] - r0, 1);
            chk($sformatf("v%0d_rx_byte", v),   rx_last[s], vecs[v].exp_rx);
            chk($sformatf("v%0d_miso", v),      mi, vecs[v].exp_mi);
            chk($sformatf("v%0d_underrun", v),  und_at_rx[s] - u0, vecs[v].exp_und);
            chk($sformatf("v%0d_idle_en", v),   miso_en[s], 0);
        end

        // Back-to-back words in one frame, second TX word written once ready re-rises.
        chk("b2b_ready_start", tx_ready[0], 1);
        tx_write(0, 8'h11);
        r0 = rx_cnt[0];
        u0 = und_cnt[0];
        cs_n[0] = 1'b0;
        ok = 1'b0;
        for (int unsigned k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (tx_ready[0] === 1'b1) ok = 1'b1;
        end
        chk("b2b_ready_rise", ok, 1);
        tx_write(0, 8'h22);
        chk("b2b_en_active", miso_en[0], 1);
        wait_clk(4);
        xfer(0, 8'hC3, mi);
        xfer(0, 8'h5A, mi2);
        wait_clk(4);
        cs_n[0] = 1'b1;
        wait_clk(8);
        chk("b2b_rx_pulses", rx_cnt[0] - r0, 2);
        chk("b2b_rx_first",  rx_prev[0], 8'hC3);
        chk("b2b_rx_second", rx_last[0], 8'h5A);
        chk("b2b_miso_first",  mi,  8'h11);
        chk("b2b_miso_second", mi2, 8'h22);
        chk("b2b_underrun_before_rx", und_at_rx[0] - u0, 0);

        // Abort after 5 bits; a word written mid-frame must survive into the next frame.
        r0 = rx_cnt[0];
        cs_n[0] = 1'b0;
        wait_clk(8);
        tx_write(0, 8'h6B);
        for (int unsigned k = 0; k < 5; k++) begin
            mosi[0] = k[0];
            wait_clk(4);
            sck[0] = 1'b1;
            wait_clk(4);
            sck[0] = 1'b0;
        end
        wait_clk(4);
        cs_n[0] = 1'b1;
        wait_clk(8);
        chk("abort_no_rx",   rx_cnt[0] - r0, 0);
        chk("abort_en_low",  miso_en[0], 0);
        chk("abort_miso_hi", miso[0], 1);
        chk("abort_ready",   tx_ready[0], 0);
        frame(0, 8'h81, mi);
        chk("abort_next_rx_pulses", rx_cnt[0] - r0, 1);
        chk("abort_next_rx_byte",   rx_last[0], 8'h81);
        chk("abort_next_miso",      mi, 8'h6B);

        // Reset at bit 4 of a frame with a buffered TX word.
        r0 = rx_cnt[0];
        cs_n[0] = 1'b0;
        wait_clk(8);
        for (int unsigned k = 0; k < 4; k++) begin
            mosi[0] = 1'b1;
            wait_clk(4);
            sck[0] = 1'b1;
            wait_clk(4);
            sck[0] = 1'b0;
        end
        tx_write(0, 8'h77);
        chk("mid_ready_low", tx_ready[0], 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready",  tx_ready[0], 1);
        chk("mid_rst_miso",   miso[0], 1);
        chk("mid_rst_en",     miso_en[0], 0);
        chk("mid_rst_rxbyte", rx_byte[0], 0);
        chk("mid_rst_und",    und[0], 0);
        rst     = 1'b0;
        cs_n[0] = 1'b1;
        wait_clk(12);
        chk("mid_rst_no_rx", rx_cnt[0] - r0, 0);
        frame(0, 8'h3C, mi);
        chk("post_rst_rx_pulses", rx_cnt[0] - r0, 1);
        chk("post_rst_rx_byte",   rx_last[0], 8'h3C);
        chk("post_rst_miso",      mi, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
